cga_vram_sequencer: RTL and testbench

Master timing sequencer and VRAM arbiter for the CGA display path.
- Generates the 5-bit clk_seq phase counter and the fetch strobes consumed by the pixel/attribute pipeline: vram_read_char, vram_read_att, charrom_read, disp_pipeline.
- Time-multiplexes the single-port 16 KB VRAM between display fetches and a one-deep CPU request channel.
- Sits between the CRTC/bus interface and the pixel pipeline.

---
 rtl/cga_vram_sequencer_pkg.sv | 23 ++
 rtl/cga_vram_sequencer_if.sv | 14 +
 rtl/cga_vram_sequencer_cpu_port.sv | 52 +++++
 rtl/cga_vram_sequencer.sv | 109 ++++++++++
 tb/tb_cga_vram_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cga_vram_sequencer_pkg.sv
// Shared phase constants and CPU port state encoding for the CGA VRAM sequencer.
// Optional snow emulation is selected by the CGA_SNOW_EN macro in the top level.
package cga_pkg;

  // Offsets within a 16-cycle fetch half, relative to the base phase d
  localparam logic [3:0] OFF_CHAR_ADDR = 4'd0;
  localparam logic [3:0] OFF_ATT_ADDR  = 4'd1;
  localparam logic [3:0] STB_CHAR      = 4'd1;
  localparam logic [3:0] STB_ATT       = 4'd2;
  localparam logic [3:0] STB_ROM       = 4'd3;
  localparam logic [3:0] STB_PIPE      = 4'd4;

  localparam int CPU_SLOT_A_DEF = 8;
  localparam int CPU_SLOT_B_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } cpu_state_t;

endpackage

// File: rtl/cga_vram_sequencer_if.sv
// One-deep CPU request channel into the VRAM sequencer.
interface cga_vram_sequencer_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;

  modport master (output cpu_req, output cpu_we, output cpu_addr, output cpu_wdata,
                  input cpu_rdata, input cpu_ack);
  modport slave  (input cpu_req, input cpu_we, input cpu_addr, input cpu_wdata,
                  output cpu_rdata, output cpu_ack);
endinterface

// File: rtl/cga_vram_sequencer_cpu_port.sv
// CPU request holding registers, access FSM and ack/read-data generation.
module cga_cpu_port
  import cga_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 grant,
  input  logic [7:0]           vram_data,
  cga_vram_sequencer_if.slave  cpu,
  output logic                 pend,
  output logic                 held_we,
  output logic [13:0]          held_addr,
  output logic [7:0]           held_wdata
);

  cpu_state_t state;

  assign pend = (state == ST_PEND);

  // DONE spans slot+1 (read data valid) and slot+2 (ack visible)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      cpu.cpu_ack   <= 1'b0;
      cpu.cpu_rdata <= 8'd0;
    end else begin
      cpu.cpu_ack <= 1'b0;
      unique case (state)
        ST_IDLE:   if (cpu.cpu_req) state <= ST_PEND;
        ST_PEND:   if (grant) state <= ST_ACCESS;
        ST_ACCESS: state <= ST_DONE;
        ST_DONE: begin
          if (!cpu.cpu_ack) begin
            cpu.cpu_ack <= 1'b1;
            if (!held_we) cpu.cpu_rdata <= vram_data;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && cpu.cpu_req) begin
      held_we    <= cpu.cpu_we;
      held_addr  <= cpu.cpu_addr;
      held_wdata <= cpu.cpu_wdata;
    end
  end

endmodule

// File: rtl/cga_vram_sequencer.sv
// CGA phase counter, display fetch strobes and VRAM arbitration between display and CPU.
// Define CGA_SNOW_EN to service CPU requests on the attribute phase in 80-column text (snow).
module cga_vram_sequencer
  import cga_pkg::*;
#(
  parameter int CPU_SLOT_A = CPU_SLOT_A_DEF,
  parameter int CPU_SLOT_B = CPU_SLOT_B_DEF
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hres_mode,
  input  logic                 grph_mode,
  input  logic [12:0]          crtc_addr,
  input  logic [4:0]           row_addr,
  input  logic [7:0]           vram_data,
  output logic [13:0]          vram_addr,
  output logic                 vram_we,
  output logic [7:0]           vram_wdata,
  output logic [4:0]           clk_seq,
  output logic                 vram_read_char,
  output logic                 vram_read_att,
  output logic                 charrom_read,
  output logic                 disp_pipeline,
  cga_vram_sequencer_if.slave  cpu
);

  logic [4:0]  seq_next;
  logic [3:0]  off;
  logic        hi_fetch;
  logic        fetch_en;
  logic [13:0] char_addr;
  logic        slot_hit;
  logic        snow_mode;
  logic        snow_hit;
  logic        grant;
  logic        pend;
  logic        held_we;
  logic [13:0] held_addr;
  logic [7:0]  held_wdata;
  logic        unused_row;

  // All registered outputs are decoded from the phase they will show next
  assign seq_next = clk_seq + 5'd1;
  assign off      = seq_next[3:0];

  // Upper half fetches only when hres was set at its base phase
  always_comb begin
    fetch_en = 1'b1;
    if (seq_next[4]) fetch_en = (off == OFF_CHAR_ADDR) ? hres_mode : hi_fetch;
  end

  assign char_addr  = grph_mode ? {row_addr[0], crtc_addr[11:0], 1'b0} : {crtc_addr, 1'b0};
  assign unused_row = &{1'b0, row_addr[4:1]};
  assign slot_hit   = (seq_next == 5'(CPU_SLOT_A)) || (seq_next == 5'(CPU_SLOT_B));

`ifdef CGA_SNOW_EN
  assign snow_mode = hres_mode & ~grph_mode;
  assign snow_hit  = snow_mode & fetch_en & (off == OFF_ATT_ADDR);
`else
  assign snow_mode = 1'b0;
  assign snow_hit  = 1'b0;
`endif

  assign grant = pend & (snow_mode ? snow_hit : slot_hit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_seq        <= 5'd0;
      hi_fetch       <= 1'b0;
      vram_addr      <= 14'd0;
      vram_we        <= 1'b0;
      vram_wdata     <= 8'd0;
      vram_read_char <= 1'b0;
      vram_read_att  <= 1'b0;
      charrom_read   <= 1'b0;
      disp_pipeline  <= 1'b0;
    end else begin
      clk_seq <= seq_next;
      if (seq_next == 5'd16) hi_fetch <= hres_mode;
      vram_we <= 1'b0;
      if (grant) begin
        vram_addr  <= held_addr;
        vram_we    <= held_we;
        vram_wdata <= held_wdata;
      end else if (fetch_en && off == OFF_CHAR_ADDR) begin
        vram_addr <= char_addr;
      end else if (fetch_en && off == OFF_ATT_ADDR) begin
        vram_addr <= {char_addr[13:1], 1'b1};
      end
      vram_read_char <= fetch_en && (off == STB_CHAR);
      vram_read_att  <= fetch_en && (off == STB_ATT);
      charrom_read   <= fetch_en && (off == STB_ROM);
      disp_pipeline  <= fetch_en && (off == STB_PIPE);
    end
  end

  cga_cpu_port u_cpu (
    .clk        (clk),
    .reset      (reset),
    .grant      (grant),
    .vram_data  (vram_data),
    .cpu        (cpu),
    .pend       (pend),
    .held_we    (held_we),
    .held_addr  (held_addr),
    .held_wdata (held_wdata)
  );

endmodule

// File: tb/tb_cga_vram_sequencer.sv
// Directed bench for cga_vram_sequencer with a small single-port VRAM model.
module tb_cga_vram_sequencer;

  logic        clk;
  logic        reset;
  logic        hres_mode;
  logic        grph_mode;
  logic [12:0] crtc_addr;
  logic [4:0]  row_addr;
  logic [7:0]  vram_data;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [4:0]  clk_seq;
  logic        vram_read_char;
  logic        vram_read_att;
  logic        charrom_read;
  logic        disp_pipeline;
  logic [7:0]  mem [0:16383];
  int          checks;
  int          errors;
  int          n_ack;
  int          n_we;

  cga_vram_sequencer_if bus ();

  cga_vram_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .hres_mode      (hres_mode),
    .grph_mode      (grph_mode),
    .crtc_addr      (crtc_addr),
    .row_addr       (row_addr),
    .vram_data      (vram_data),
    .vram_addr      (vram_addr),
    .vram_we        (vram_we),
    .vram_wdata     (vram_wdata),
    .clk_seq        (clk_seq),
    .vram_read_char (vram_read_char),
    .vram_read_att  (vram_read_att),
    .charrom_read   (charrom_read),
    .disp_pipeline  (disp_pipeline),
    .cpu            (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (vram_we) mem[vram_addr] <= vram_wdata;
    vram_data <= mem[vram_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_seq(input logic [4:0] s);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (clk_seq !== s && n < 64);
    chk("wait_seq", clk_seq, s);
  endtask

  function automatic logic [3:0] stb_exp(input logic [4:0] s, input logic hres);
    stb_exp = {(s == 5'd1) || (hres && s == 5'd17),
               (s == 5'd2) || (hres && s == 5'd18),
               (s == 5'd3) || (hres && s == 5'd19),
               (s == 5'd4) || (hres && s == 5'd20)};
  endfunction

  initial begin
    logic [4:0] es;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
    reset = 1'b1;
    hres_mode = 1'b0;
    grph_mode = 1'b0;
    crtc_addr = 13'd0;
    row_addr = 5'd0;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 14'd0;
    bus.cpu_wdata = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_seq", clk_seq, 5'd0);
    chk("rst_addr", vram_addr, 14'd0);
    chk("rst_we", vram_we, 1'b0);
    chk("rst_wdata", vram_wdata, 8'd0);
    chk("rst_stb", {vram_read_char, vram_read_att, charrom_read, disp_pipeline}, 4'd0);
    chk("rst_ack", bus.cpu_ack, 1'b0);
    chk("rst_rdata", bus.cpu_rdata, 8'd0);
    reset = 1'b0;

    // Low-res strobe schedule over two full wraps
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      es = 5'(i);
      chk("t1_seq", clk_seq, es);
      chk("t1_stb", {vram_read_char, vram_read_att, charrom_read, disp_pipeline}, stb_exp(es, 1'b0));
    end

    // 80-column text: two fetches per slot
    hres_mode = 1'b1;
    crtc_addr = 13'h0123;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      es = 5'(i);
      chk("t2_stb", {vram_read_char, vram_read_att, charrom_read, disp_pipeline}, stb_exp(es, 1'b1));
      chk("t2_addr", vram_addr, (es == 5'd0 || es == 5'd16) ? 14'h0246 : 14'h0247);
      chk("t2_we", vram_we, 1'b0);
    end

    // Graphics addressing with bank select
    grph_mode = 1'b1;
    row_addr = 5'd1;
    crtc_addr = 13'h0ABC;
    wait_seq(5'd0);
    chk("t3_addr0", vram_addr, 14'h3578);
    @(negedge clk);
    chk("t3_addr1", vram_addr, 14'h3579);
    wait_seq(5'd16);
    chk("t3_addr16", vram_addr, 14'h3578);
    hres_mode = 1'b0;
    grph_mode = 1'b0;
    row_addr = 5'd0;
    crtc_addr = 13'h0010;

    // CPU write in slot A
    wait_seq(5'd2);
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 14'h1FFF;
    bus.cpu_wdata = 8'h5A;
    for (int s = 3; s <= 11; s++) begin
      @(negedge clk);
      chk("t4w_seq", clk_seq, 5'(s));
      chk("t4w_we", vram_we, s == 8);
      chk("t4w_ack", bus.cpu_ack, s == 10);
      if (s == 8) begin
        chk("t4w_addr", vram_addr, 14'h1FFF);
        chk("t4w_wdata", vram_wdata, 8'h5A);
      end
      if (bus.cpu_ack) bus.cpu_req = 1'b0;
    end

    // CPU read-back in slot B
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 14'h1FFF;
    for (int s = 12; s <= 27; s++) begin
      @(negedge clk);
      chk("t4r_we", vram_we, 1'b0);
      chk("t4r_ack", bus.cpu_ack, s == 26);
      if (s == 24) chk("t4r_addr", vram_addr, 14'h1FFF);
      if (s == 26) chk("t4r_rdata", bus.cpu_rdata, 8'h5A);
      if (bus.cpu_ack) bus.cpu_req = 1'b0;
    end

    // Reset while a read is pending drops it
    wait_seq(5'd9);
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 14'h0100;
    wait_seq(5'd20);
    reset = 1'b1;
    #1;
    chk("t5_seq", clk_seq, 5'd0);
    chk("t5_we", vram_we, 1'b0);
    chk("t5_ack", bus.cpu_ack, 1'b0);
    bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_ack = 0;
    n_we = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.cpu_ack) n_ack++;
      if (vram_we) n_we++;
    end
    chk("t5_no_ack", n_ack, 0);
    chk("t5_no_we", n_we, 0);

    // Reset during the write slot drops vram_we at once
    wait_seq(5'd2);
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 14'h0300;
    bus.cpu_wdata = 8'hC3;
    wait_seq(5'd8);
    chk("t5w_we_on", vram_we, 1'b1);
    reset = 1'b1;
    #1;
    chk("t5w_we_off", vram_we, 1'b0);
    bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_ack = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.cpu_ack) n_ack++;
    end
    chk("t5w_no_ack", n_ack, 0);

    // 80-column text request raised at seq 14
    hres_mode = 1'b1;
    grph_mode = 1'b0;
    wait_seq(5'd14);
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 14'h0200;
`ifdef CGA_SNOW_EN
    for (int s = 15; s <= 20; s++) begin
      @(negedge clk);
      chk("t6_ack", bus.cpu_ack, s == 19);
      if (s == 17) chk("t6_addr", vram_addr, 14'h0200);
      if (s == 18) chk("t6_att", vram_read_att, 1'b1);
      if (bus.cpu_ack) bus.cpu_req = 1'b0;
    end
`else
    for (int s = 15; s <= 27; s++) begin
      @(negedge clk);
      chk("t6_ack", bus.cpu_ack, s == 26);
      chk("t6_we", vram_we, 1'b0);
      if (s == 17) chk("t6_addr17", vram_addr, 14'h0021);
      if (s == 24) chk("t6_addr24", vram_addr, 14'h0200);
      if (bus.cpu_ack) bus.cpu_req = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
